// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI command controller.
// Holds the FSM state encoding and the command-byte field layout.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_READ,
        ST_ERR
    } state_e;

    localparam int         CMD_RW_BIT    = 7;
    localparam logic [6:0] STATUS_ADDR   = 7'h7F;
    localparam logic [7:0] ID_BYTE_DFLT  = 8'h4E;
    localparam logic [7:0] ERR_BYTE_DFLT = 8'hEE;

endpackage

// File: rtl/spi_reg_bank.sv
// Register bank with an SPI write port that beats the local port.
// Reads are a plain combinational mux; contents also exported flat.
module spi_reg_bank #(
    parameter int NREGS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     spi_we_i,
    input  logic [$clog2(NREGS)-1:0] spi_addr_i,
    input  logic [7:0]               spi_data_i,
    input  logic                     loc_we_i,
    input  logic [$clog2(NREGS)-1:0] loc_addr_i,
    input  logic [7:0]               loc_data_i,
    input  logic [$clog2(NREGS)-1:0] rd_addr_i,
    output logic [7:0]               rd_data_o,
    output logic [8*NREGS-1:0]       regs_flat_o
);

    localparam int AW = $clog2(NREGS);

    logic [7:0] regs_q [NREGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (spi_we_i && spi_addr_i == AW'(i)) begin
                    regs_q[i] <= spi_data_i;
                end else if (loc_we_i && loc_addr_i == AW'(i)) begin
                    regs_q[i] <= loc_data_i;
                end
            end
        end
    end

    assign rd_data_o = regs_q[rd_addr_i];

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat_o[8*g +: 8] = regs_q[g];
    end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: decodes the command byte, walks the address,
// commits writes and stages the next MISO byte for the shifter.
module spi_cmd_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int         NREGS    = 8,
    parameter logic [7:0] ID_BYTE  = ID_BYTE_DFLT,
    parameter logic [7:0] ERR_BYTE = ERR_BYTE_DFLT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     frame_end,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_byte,
    input  logic                     tx_take,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    input  logic                     local_we,
    input  logic [$clog2(NREGS)-1:0] local_addr,
    input  logic [7:0]               local_data,
    output logic                     local_busy,
    output logic                     wr_strobe,
    output logic [$clog2(NREGS)-1:0] wr_addr,
    output logic [7:0]               wr_data,
    output logic [8*NREGS-1:0]       regs_flat,
    input  logic [7:0]               status_in,
    output logic                     err,
    output logic                     underrun
);

    localparam int            AW  = $clog2(NREGS);
    localparam logic [AW-1:0] ONE = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          stat_q, stat_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_valid_q, tx_valid_d;
    logic          err_q, err_d;
    logic          underrun_q, underrun_d;
    logic          wr_strobe_q;
    logic [AW-1:0] wr_addr_q;
    logic [7:0]    wr_data_q;
    logic          local_busy_q;

    logic          spi_we;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [6:0]    cmd_addr;
    logic          collide;

    assign cmd_addr = rx_byte[6:0];
    assign collide  = spi_we && local_we && (local_addr == addr_q);

    spi_reg_bank #(
        .NREGS(NREGS)
    ) u_bank (
        .clk_i      (clk),
        .rst_i      (rst),
        .spi_we_i   (spi_we),
        .spi_addr_i (addr_q),
        .spi_data_i (rx_byte),
        .loc_we_i   (local_we),
        .loc_addr_i (local_addr),
        .loc_data_i (local_data),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .regs_flat_o(regs_flat)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stat_d     = stat_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        err_d      = err_q;
        underrun_d = underrun_q;
        spi_we     = 1'b0;
        rd_addr    = addr_q + ONE;

        if (tx_take) begin
            if (tx_valid_q) tx_valid_d = 1'b0;
            else            underrun_d = 1'b1;
        end

        if (rx_valid) begin
            case (state_q)
                ST_CMD: begin
                    addr_d     = rx_byte[AW-1:0];
                    rd_addr    = rx_byte[AW-1:0];
                    stat_d     = 1'b0;
                    tx_valid_d = 1'b1;
                    if (cmd_addr < 7'(NREGS)) begin
                        if (rx_byte[CMD_RW_BIT]) begin
                            state_d   = ST_READ;
                            tx_byte_d = rd_data;
                        end else begin
                            state_d   = ST_WRITE;
                            tx_byte_d = 8'h00;
                        end
                    end else if (cmd_addr == STATUS_ADDR) begin
                        stat_d = 1'b1;
                        if (rx_byte[CMD_RW_BIT]) begin
                            state_d   = ST_READ;
                            tx_byte_d = status_in;
                        end else begin
                            state_d   = ST_WRITE;
                            tx_byte_d = 8'h00;
                        end
                    end else begin
                        state_d   = ST_ERR;
                        err_d     = 1'b1;
                        tx_byte_d = ERR_BYTE;
                    end
                end
                ST_WRITE: begin
                    // the status address swallows writes and never advances
                    spi_we     = !stat_q;
                    addr_d     = stat_q ? addr_q : addr_q + ONE;
                    tx_byte_d  = rx_byte;
                    tx_valid_d = 1'b1;
                end
                ST_READ: begin
                    addr_d     = stat_q ? addr_q : addr_q + ONE;
                    tx_byte_d  = stat_q ? status_in : rd_data;
                    tx_valid_d = 1'b1;
                end
                ST_ERR: begin
                    tx_byte_d  = ERR_BYTE;
                    tx_valid_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (frame_end) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
        end

        if (frame_start) begin
            state_d    = ST_CMD;
            tx_byte_d  = ID_BYTE;
            tx_valid_d = 1'b1;
            err_d      = 1'b0;
            underrun_d = 1'b0;
            spi_we     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            stat_q       <= 1'b0;
            tx_byte_q    <= ID_BYTE;
            tx_valid_q   <= 1'b0;
            err_q        <= 1'b0;
            underrun_q   <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            local_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            stat_q       <= stat_d;
            tx_byte_q    <= tx_byte_d;
            tx_valid_q   <= tx_valid_d;
            err_q        <= err_d;
            underrun_q   <= underrun_d;
            wr_strobe_q  <= spi_we;
            local_busy_q <= collide;
            if (spi_we) begin
                wr_addr_q <= addr_q;
                wr_data_q <= rx_byte;
            end
        end
    end

    assign tx_byte    = tx_byte_q;
    assign tx_valid   = tx_valid_q;
    assign err        = err_q;
    assign underrun   = underrun_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign local_busy = local_busy_q;

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command controller that sequences the byte-level SPI slave shifter and arbitrates access to a small register bank. It sits between the shifter and application logic. The shifter supplies frame and byte events; this block decodes the command byte, auto-increments the address, commits writes and stages the next MISO byte. A local requester can also write the bank, and the block arbitrates that port against SPI.

## Interface
- NREGS, 8: number of 8-bit registers; power of two, 2..64
- ID_BYTE, 8'h4E: byte returned while the command byte is clocked in
- ERR_BYTE, 8'hEE: byte returned after an invalid address
- clk  in  1  system clock
- rst  in  1  reset; asynchronous assert, active-high
- frame_start  in  1  one-cycle pulse on SSEL falling edge (from shifter)
- frame_end  in  1  one-cycle pulse on SSEL rising edge
- rx_valid  in  1  one-cycle pulse: a complete MOSI byte is available
- rx_byte  in  8  received byte; valid with rx_valid
- tx_take  in  1  one-cycle pulse: shifter latched tx_byte for the next byte slot
- tx_byte  out  8  next MISO byte
- tx_valid  out  1  tx_byte is staged and not yet taken
- local_we  in  1  local write request
- local_addr  in  $clog2(NREGS)  local write address
- local_data  in  8  local write data
- local_busy  out  1  local write refused this cycle (SPI won)
- wr_strobe  out  1  one-cycle pulse per committed SPI write
- wr_addr  out  $clog2(NREGS)  address of the SPI write
- wr_data  out  8  data of the SPI write
- regs_flat  out  8*NREGS  register bank contents; reg i at bits [8i+7:8i]
- status_in  in  8  value returned on reads of address 7'h7F
- err  out  1  sticky invalid-address flag; cleared on frame_start
- underrun  out  1  sticky: tx_take seen with tx_valid=0; cleared on frame_start

## Operation
- States:
  - IDLE: outside a frame.
  - CMD: waiting for the command byte.
  - WRITE, READ: data phase.
  - ERR: rest of frame is ignored.
- Reset values:
  - state IDLE; all registers 0.
  - tx_byte = ID_BYTE; tx_valid = 0.
  - wr_strobe, local_busy, err, underrun = 0.
- frame_start, from any state: go to CMD; tx_byte = ID_BYTE, tx_valid = 1; clear err and underrun. It overrides every other event in the same cycle.
- Command byte (CMD + rx_valid): bit7 = 1 means read, 0 means write; bits [6:0] are the address.
  - addr < NREGS:
    - Write: go to WRITE; tx_byte = 8'h00.
    - Read: go to READ; tx_byte = reg[addr].
  - addr == 7'h7F:
    - Read: go to READ; tx_byte = status_in, sampled in the rx_valid cycle.
    - Write: go to WRITE with all writes discarded.
  - Any other addr: go to ERR; err = 1; tx_byte = ERR_BYTE.
  - In every case tx_valid = 1.
- WRITE + rx_valid:
  - reg[addr] <= rx_byte.
  - Pulse wr_strobe with wr_addr/wr_data.
  - addr <= (addr + 1) mod NREGS.
  - tx_byte = rx_byte (echo); tx_valid = 1.
- READ + rx_valid: addr <= (addr + 1) mod NREGS; tx_byte = reg[new addr]; tx_valid = 1.
- Address 7'h7F never increments:
  - Each READ byte re-samples status_in.
  - Writes produce no wr_strobe.
- ERR + rx_valid: tx_byte = ERR_BYTE; nothing else changes.
- tx_take: clears tx_valid. If tx_valid was 0, set underrun and leave tx_byte unchanged.
- frame_end: go to IDLE; tx_valid = 0. If rx_valid arrives in the same cycle, that byte is processed first (a write commits), then the state goes to IDLE.
- Local write:
  - local_we applies in any state.
  - If SPI commits to the same address in the same cycle, SPI wins and local_busy = 1 for that cycle.
  - A local write to a different address commits in parallel.

## Timing
- All outputs are registered.
- tx_byte and tx_valid update 1 cycle after rx_valid or frame_start. The shifter needs at least 2 clk per SCK bit, so the byte is ready before the next slot.
- wr_strobe asserts the cycle after rx_valid and lasts 1 cycle.
- A register written in cycle N is visible on regs_flat in cycle N+1. A READ staged in cycle N+1 sees the write from cycle N.
- Asserting rst mid-frame forces IDLE immediately. The remainder of the frame is ignored until the next frame_start.

## Structure
- Package spi_ctrl_pkg holds:
  - state enum (IDLE, CMD, WRITE, READ, ERR)
  - CMD_RW_BIT = 7
  - STATUS_ADDR = 7'h7F
  - ID_BYTE and ERR_BYTE defaults
- Sub-module spi_reg_bank:
  - NREGS×8 storage with two write ports (SPI has priority over local).
  - Combinational read mux; flat output.
- The FSM, address counter and tx staging stay in spi_cmd_ctrl.

## Test plan
- Write 2 bytes: frame_start, rx 8'h02, 8'hA5, 8'h3C, frame_end (NREGS=8) → reg2 = A5, reg3 = 3C; two wr_strobe pulses; tx sequence 4E, 00, A5; state IDLE at end.
- Read with wrap-around: regs 6 and 7 = 11, 22, reg0 = 33; rx 8'h86 then 3 dummy bytes → tx 4E, 11, 22, 33.
- Status read: status_in = 5A; rx 8'hFF, then a dummy byte while status_in = 5B → tx 4E, 5A, 5B; address stays at 7F.
- Invalid address: rx 8'h10 → err = 1; following bytes return EE; no wr_strobe; next frame_start clears err.
- Collision: SPI write of 77 to reg1 in the same cycle as local_we to reg1 with 99 → reg1 = 77, local_busy pulses. A local write to reg4 in the same cycle commits.
- Abort and underrun:
  - rst asserted mid-READ → all outputs return to reset values immediately.
  - tx_take with tx_valid = 0 → underrun = 1.
